scr_write_queue: RTL and testbench
==================================

// Module: scr_write_queue
// PURPOSE
//  Host-side write path into screen_ram, between the synchronised CPU register bus and the RAM write port.
//  Holds the write cursor (ADDR_LO/ADDR_HI), auto-increments it, and buffers {address,data} pairs in a FIFO.
//  Provides a hardware FILL engine for clearing or filling screen regions.
//  Drains the FIFO only in write slots granted by the display arbiter, so scan-out reads are never disturbed.
// PARAMETERS
//  ADDR_W      16       screen RAM address width
//  FIFO_DEPTH  16       queue entries; power of two, >=4
//  SCR_LAST    16'h12BF last valid screen address; the cursor wraps to 0 after it (80x60 text = 4800 cells)
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  wr_stb         in   1       one-cycle host register write strobe (already synchronised to clk)
//  wr_sel         in   4       register select
//  wr_data        in   8       register write data
//  ram_grant      in   1       arbiter allows a screen RAM write this cycle
//  ram_wraddress  out  ADDR_W  screen RAM write address (registered)
//  ram_data       out  8       screen RAM write data (registered)
//  ram_wren       out  1       screen RAM write enable, one cycle per word (registered)
//  busy           out  1       FILL active or FIFO not empty
//  overflow       out  1       sticky: a write was dropped
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  current number of queued entries
// BEHAVIOUR
//  Reset (async, rst_n=0) clears: cursor=0, ctrl=0, fill_cnt=0, FIFO empty, FSM=IDLE, all outputs 0.
//  Register map (acted on at the clk edge where wr_stb=1):
//   sel 1 DATA: latch data_reg; push {cursor,wr_data}; if ctrl[0]=1, advance the cursor.
//   sel 3 ADDR_LO: cursor[7:0]. sel 4 ADDR_HI: cursor[15:8]. Loaded values are not range-checked.
//   sel 5 CTRL: bit0 = auto-increment enable; bit7=1 clears overflow (bit7 is not stored).
//   sel 6 CNT_LO: fill_cnt[7:0].
//   sel 7 CNT_HI: fill_cnt[15:8]; starts FILL if the resulting fill_cnt != 0; count 0 is a no-op.
//   All other sel values are ignored.
//  Cursor advance: if cursor==SCR_LAST then 0, else cursor+1. Cursor values above SCR_LAST wrap only via 16-bit overflow.
//  FSM IDLE->FILL on a start. In FILL, every cycle the FIFO is not full:
//   - push {cursor,data_reg};
//   - advance the cursor (ctrl[0] is ignored during FILL);
//   - fill_cnt--.
//  FILL->IDLE on the cycle of the push that takes fill_cnt to 0.
//  During FILL, host writes to sel 1/3/4/6/7 are dropped and set overflow; sel 5 is still honoured.
//  Push while the FIFO is full (full evaluated before this cycle's pop, no bypass): entry dropped, overflow=1.
//  Drain: at an edge with ram_grant=1 and FIFO not empty, pop the head.
//   - Next cycle: ram_wren=1, ram_wraddress/ram_data = popped entry.
//   - Otherwise ram_wren=0; address/data hold their last values.
//  Simultaneous push and pop on a non-full FIFO are both performed; the level is unchanged.
//  Latency: DATA strobe at edge N -> entry queued after N -> popped at N+1 if granted -> ram_wren high in cycle N+1..N+2.
//  Order is strictly FIFO. At most one push and one pop per cycle. Pointers wrap modulo FIFO_DEPTH.
//  Reset mid-FILL or mid-drain: queued entries are discarded and no further ram_wren pulses occur.
//  busy = (FSM==FILL) | (fifo_level!=0).
// TESTING
//  1 Write ADDR_LO=0x10, ADDR_HI=0x00, CTRL=0x01, DATA 0x41,0x42,0x43 with ram_grant=1
//    -> ram_wren pulses at 0x0010/41, 0x0011/42, 0x0012/43; cursor ends at 0x0013; busy then drops to 0.
//  2 Cursor=0x12BF, CTRL=0x01, DATA 0x55 twice -> writes at 0x12BF then 0x0000 (wrap).
//  3 ram_grant=0, 17 DATA writes -> fifo_level=16 and overflow=1.
//    Then grant=1 -> exactly the first 16 values are written, in order. CTRL=0x80 -> overflow=0.
//  4 DATA=0x20, cursor=0x0100, CNT_LO=0x05, CNT_HI=0x00, grant toggling 1/0
//    -> 5 writes of 0x20 to 0x0100..0x0104, busy until the last write, fill_cnt=0.
//  5 FILL of 0x0040 words with a DATA strobe mid-fill -> the strobe is dropped, overflow=1, the fill completes intact.
//    CNT_HI with fill_cnt=0 -> no writes.
//  6 Assert rst_n=0 for 1 cycle during a FILL with 8 entries queued
//    -> ram_wren=0 immediately, fifo_level=0, busy=0, cursor=0, and no writes after release.

Source files
------------

// File: rtl/scr_write_queue.sv
// scr_write_queue: host write cursor, FILL engine and {address,data} FIFO feeding
// the screen RAM write port in arbiter-granted slots.
`default_nettype none

module scr_write_queue #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] SCR_LAST   = 16'h12BF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_stb,
  input  logic [3:0]                      wr_sel,
  input  logic [7:0]                      wr_data,
  input  logic                            ram_grant,
  output logic [ADDR_W-1:0]               ram_wraddress,
  output logic [7:0]                      ram_data,
  output logic                            ram_wren,
  output logic                            busy,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              ctrl_inc_q, ctrl_inc_d;
  logic [7:0]        data_reg_q, data_reg_d;
  logic [15:0]       fill_cnt_q, fill_cnt_d;
  logic              overflow_q, overflow_d;

  logic [LVL_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [LVL_W-1:0]  level;
  logic              full, empty, push, pop;
  logic [ENT_W-1:0]  push_entry;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_data_q;
  logic              ram_wren_q;

  function automatic logic [ADDR_W-1:0] next_cursor(input logic [ADDR_W-1:0] c);
    return (c == SCR_LAST) ? '0 : c + ADDR_W'(1);
  endfunction

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = ram_grant && !empty;

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    ctrl_inc_d = ctrl_inc_q;
    data_reg_d = data_reg_q;
    fill_cnt_d = fill_cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_entry = '0;

    if (wr_stb && wr_sel == 4'd5) begin
      ctrl_inc_d = wr_data[0];
      if (wr_data[7]) overflow_d = 1'b0;
    end

    if (state_q == ST_FILL) begin
      case (wr_sel)
        4'd1, 4'd3, 4'd4, 4'd6, 4'd7: if (wr_stb) overflow_d = 1'b1;
        default: ;
      endcase
      // The fill stalls rather than drops when the queue is full.
      if (!full) begin
        push       = 1'b1;
        push_entry = {cursor_q, data_reg_q};
        cursor_d   = next_cursor(cursor_q);
        fill_cnt_d = fill_cnt_q - 16'd1;
        if (fill_cnt_q == 16'd1) state_d = ST_IDLE;
      end
    end else if (wr_stb) begin
      case (wr_sel)
        4'd1: begin
          data_reg_d = wr_data;
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            push       = 1'b1;
            push_entry = {cursor_q, wr_data};
          end
          if (ctrl_inc_q) cursor_d = next_cursor(cursor_q);
        end
        4'd3: cursor_d = {cursor_q[ADDR_W-1:8], wr_data};
        4'd4: cursor_d = {wr_data, cursor_q[7:0]};
        4'd6: fill_cnt_d = {fill_cnt_q[15:8], wr_data};
        4'd7: begin
          fill_cnt_d = {wr_data, fill_cnt_q[7:0]};
          if ({wr_data, fill_cnt_q[7:0]} != 16'd0) state_d = ST_FILL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cursor_q   <= '0;
      ctrl_inc_q <= 1'b0;
      data_reg_q <= '0;
      fill_cnt_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      ctrl_inc_q <= ctrl_inc_d;
      data_reg_q <= data_reg_d;
      fill_cnt_q <= fill_cnt_d;
      overflow_q <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + LVL_W'(1);
        ram_addr_q <= mem_q[rd_ptr_q[PTR_W-1:0]][ENT_W-1:8];
        ram_data_q <= mem_q[rd_ptr_q[PTR_W-1:0]][7:0];
      end
      ram_wren_q <= pop;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end

  assign ram_wraddress = ram_addr_q;
  assign ram_data      = ram_data_q;
  assign ram_wren      = ram_wren_q;
  assign overflow      = overflow_q;
  assign fifo_level    = level;
  assign busy          = (state_q == ST_FILL) || !empty;

endmodule

`default_nettype wire

// File: tb/tb_scr_write_queue.sv
// Scoreboard bench for scr_write_queue: a queue-level reference model predicts every
// RAM write; a monitor compares DUT writes and status against it each cycle.
`default_nettype none

module tb_scr_write_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_stb;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        ram_grant;
  logic [15:0] ram_wraddress;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        overflow;
  logic [4:0]  fifo_level;

  scr_write_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_stb        (wr_stb),
    .wr_sel        (wr_sel),
    .wr_data       (wr_data),
    .ram_grant     (ram_grant),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .busy          (busy),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_writes = 0;
  logic [15:0] last_addr = '0;

  // Reference model state
  logic [15:0] m_cur, m_cnt;
  logic [7:0]  m_dreg;
  logic        m_ctrl, m_fill, m_ovf;
  logic [23:0] mq[$];
  logic [23:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] c);
    return (c == 16'h12BF) ? 16'h0000 : c + 16'd1;
  endfunction

  // Reference model: queue of pending words plus the register file
  initial begin
    logic was_full;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cur = '0; m_cnt = '0; m_dreg = '0; m_ctrl = 0; m_fill = 0; m_ovf = 0;
        mq.delete(); expq.delete();
      end else begin
        was_full = (mq.size() == DEPTH);
        if (ram_grant && mq.size() != 0) expq.push_back(mq.pop_front());
        if (wr_stb && wr_sel == 4'd5) begin
          m_ctrl = wr_data[0];
          if (wr_data[7]) m_ovf = 0;
        end
        if (m_fill) begin
          if (wr_stb && wr_sel inside {4'd1, 4'd3, 4'd4, 4'd6, 4'd7}) m_ovf = 1;
          if (!was_full) begin
            mq.push_back({m_cur, m_dreg});
            m_cur = adv(m_cur);
            m_cnt = m_cnt - 16'd1;
            if (m_cnt == 0) m_fill = 0;
          end
        end else if (wr_stb) begin
          case (wr_sel)
            4'd1: begin
              m_dreg = wr_data;
              if (was_full) m_ovf = 1;
              else mq.push_back({m_cur, wr_data});
              if (m_ctrl) m_cur = adv(m_cur);
            end
            4'd3: m_cur[7:0]  = wr_data;
            4'd4: m_cur[15:8] = wr_data;
            4'd6: m_cnt[7:0]  = wr_data;
            4'd7: begin
              m_cnt[15:8] = wr_data;
              if (m_cnt != 0) m_fill = 1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT write, checks status every cycle
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (ram_wren) begin
        n_writes++;
        last_addr = ram_wraddress;
        if (expq.size() == 0) begin
          chk("unexpected_write", {8'h0, ram_wraddress, ram_data}, 32'hFFFFFFFF);
        end else begin
          e = expq.pop_front();
          chk("write_addr", {16'h0, ram_wraddress}, {16'h0, e[23:8]});
          chk("write_data", {24'h0, ram_data}, {24'h0, e[7:0]});
        end
      end else if (expq.size() != 0) begin
        chk("missing_write", 32'd0, 32'd1);
        void'(expq.pop_front());
      end
      chk("fifo_level", {27'h0, fifo_level}, mq.size());
      chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
      chk("busy", {31'h0, busy}, {31'h0, (m_fill || mq.size() != 0)});
    end
  end

  // Called at a falling edge; leaves the strobe low at the next falling edge
  task automatic wreg(input logic [3:0] sel, input logic [7:0] d);
    wr_stb = 1'b1; wr_sel = sel; wr_data = d;
    @(negedge clk);
    wr_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input bit toggle);
    int i;
    i = 0;
    while (busy && i < 3000) begin
      if (toggle) ram_grant = ~ram_grant;
      @(negedge clk);
      i++;
    end
    if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
    ram_grant = 1'b1;
    idle(2);
  endtask

  initial begin
    int base;
    int w;
    rst_n = 1'b0; wr_stb = 1'b0; wr_sel = '0; wr_data = '0; ram_grant = 1'b0;
    idle(2);
    chk("rst_wren", {31'h0, ram_wren}, 32'd0);
    chk("rst_level", {27'h0, fifo_level}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_ovf", {31'h0, overflow}, 32'd0);
    chk("rst_addr", {16'h0, ram_wraddress}, 32'd0);
    chk("rst_data", {24'h0, ram_data}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: auto-incrementing burst
    ram_grant = 1'b1;
    base = n_writes;
    wreg(4'd3, 8'h10); wreg(4'd4, 8'h00); wreg(4'd5, 8'h01);
    wreg(4'd1, 8'h41); wreg(4'd1, 8'h42); wreg(4'd1, 8'h43);
    wait_idle(0);
    chk("t1_count", n_writes - base, 32'd3);
    chk("t1_last", {16'h0, last_addr}, 32'h0012);
    wreg(4'd1, 8'h44);
    wait_idle(0);
    chk("t1_cursor", {16'h0, last_addr}, 32'h0013);

    // 2: wrap at the last screen cell
    base = n_writes;
    wreg(4'd3, 8'hBF); wreg(4'd4, 8'h12);
    wreg(4'd1, 8'h55); wreg(4'd1, 8'h55);
    wait_idle(0);
    chk("t2_count", n_writes - base, 32'd2);
    chk("t2_wrap", {16'h0, last_addr}, 32'h0000);

    // 3: overflow on a full queue
    ram_grant = 1'b0;
    base = n_writes;
    for (int i = 0; i < 17; i++) wreg(4'd1, 8'(i));
    chk("t3_level", {27'h0, fifo_level}, 32'd16);
    chk("t3_ovf", {31'h0, overflow}, 32'd1);
    ram_grant = 1'b1;
    wait_idle(0);
    chk("t3_count", n_writes - base, 32'd16);
    wreg(4'd5, 8'h80);
    chk("t3_ovf_clr", {31'h0, overflow}, 32'd0);

    // 4: short fill with a toggling grant
    wreg(4'd1, 8'h20);
    wait_idle(0);
    base = n_writes;
    wreg(4'd3, 8'h00); wreg(4'd4, 8'h01); wreg(4'd6, 8'h05); wreg(4'd7, 8'h00);
    wait_idle(1);
    chk("t4_count", n_writes - base, 32'd5);
    chk("t4_last", {16'h0, last_addr}, 32'h0104);

    // 5: host write dropped during a fill; zero-count fill is a no-op
    base = n_writes;
    wreg(4'd6, 8'h40); wreg(4'd7, 8'h00);
    idle(10);
    wreg(4'd1, 8'h99);
    wait_idle(0);
    chk("t5_ovf", {31'h0, overflow}, 32'd1);
    chk("t5_count", n_writes - base, 32'd64);
    chk("t5_last", {16'h0, last_addr}, 32'h0144);
    wreg(4'd5, 8'h80);
    base = n_writes;
    wreg(4'd6, 8'h00); wreg(4'd7, 8'h00);
    idle(10);
    chk("t5_zero_count", n_writes - base, 32'd0);
    chk("t5_zero_busy", {31'h0, busy}, 32'd0);

    // 6: reset in the middle of a fill with eight entries queued
    ram_grant = 1'b0;
    wreg(4'd6, 8'h20); wreg(4'd7, 8'h00);
    w = 0;
    while (fifo_level != 5'd8 && w < 50) begin idle(1); w++; end
    chk("t6_level8", {27'h0, fifo_level}, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("t6_wren", {31'h0, ram_wren}, 32'd0);
    chk("t6_level", {27'h0, fifo_level}, 32'd0);
    chk("t6_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ram_grant = 1'b1;
    base = n_writes;
    idle(10);
    chk("t6_no_writes", n_writes - base, 32'd0);
    wreg(4'd1, 8'h77);
    wait_idle(0);
    chk("t6_cursor", {16'h0, last_addr}, 32'h0000);

    // Randomised traffic against the model
    for (int c = 0; c < 2000; c++) begin
      ram_grant = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 4) begin
        wr_stb = 1'b1;
        case ($urandom_range(0, 7))
          0, 1, 2: begin wr_sel = 4'd1; wr_data = 8'($urandom); end
          3: begin wr_sel = 4'd3; wr_data = 8'($urandom); end
          4: begin wr_sel = 4'd4; wr_data = 8'($urandom_range(0, 8'h13)); end
          5: begin wr_sel = 4'd5; wr_data = 8'($urandom); end
          6: begin wr_sel = 4'd6; wr_data = 8'($urandom_range(0, 24)); end
          default: begin wr_sel = 4'($urandom_range(0, 1) != 0 ? 7 : 2); wr_data = 8'h00; end
        endcase
      end else begin
        wr_stb = 1'b0;
      end
      @(negedge clk);
    end
    wr_stb = 1'b0;
    wait_idle(0);
    chk("final_scoreboard_empty", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
